psum_glb_drain: RTL and testbench

- Reader for the psum GLB port A 64-bit read path.
- Once started, it issues sequential wide reads over a programmed address window, one 64-bit word per read (FIFO_WIDTH/DATA_WIDTH packed psums).
- It streams each word to an output FIFO over a valid/ready handshake.
- It sits between the psum GLB and the off-chip output FIFO, and is the drain end of the 64-bit psum read path.

---
 rtl/psum_glb_drain_if.sv | 26 ++
 rtl/psum_glb_drain.sv | 143 ++++++++++++++
 tb/tb_psum_glb_drain.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_glb_drain_if.sv
// Bundles the psum GLB port-A read path and the output stream of the drain.
//   re_a_psum/addr_a_psum/rdata_a_psum : GLB port A read request and data
//   out_data/out_valid/out_ready       : valid/ready output stream
// master = drain side, slave = GLB + output FIFO side.
interface psum_glb_drain_if #(
  parameter int unsigned FIFO_WIDTH = 64,
  parameter int unsigned DEPTH_psum = 193600,
  parameter int unsigned ADDR_psum  = $clog2(DEPTH_psum)
);
  logic                  re_a_psum;
  logic [ADDR_psum-1:0]  addr_a_psum;
  logic [FIFO_WIDTH-1:0] rdata_a_psum;
  logic [FIFO_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output re_a_psum, addr_a_psum, out_data, out_valid,
    input  rdata_a_psum, out_ready
  );

  modport slave (
    input  re_a_psum, addr_a_psum, out_data, out_valid,
    output rdata_a_psum, out_ready
  );
endinterface

// File: rtl/psum_glb_drain.sv
// Drain end of the 64-bit psum read path: after a start pulse, reads
// num_words wide words from the psum GLB starting at base_addr and streams
// them out over valid/ready through a 2-entry credit-managed buffer.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 one-cycle pulse, ignored while busy
//   base_addr, num_words  drain window, captured on accepted start
//   busy, done            status; done pulses once per drain
//   bus (master)          GLB port A read + output stream
// Optional: define PSUM_RELU_EN to zero negative psum lanes on capture.
module psum_glb_drain #(
  parameter int unsigned FIFO_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH_psum = 193600,
  parameter int unsigned ADDR_psum  = $clog2(DEPTH_psum),
  parameter int unsigned CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_psum-1:0] base_addr,
  input  logic [CNT_W-1:0]     num_words,
  output logic                 busy,
  output logic                 done,
  psum_glb_drain_if.master     bus
);

  localparam int unsigned LANES = FIFO_WIDTH / DATA_WIDTH;
  localparam logic [ADDR_psum-1:0] ADDR_STEP = ADDR_psum'(LANES);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_psum-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]      accept_cnt_q, accept_cnt_d;
  logic                  busy_d, done_d;
  logic                  inflight_q;
  logic [FIFO_WIDTH-1:0] buf_q [2];
  logic                  rd_ptr_q, wr_ptr_q;
  logic [1:0]            occ_q;
  logic                  issue, xfer;
  logic [FIFO_WIDTH-1:0] cap_data;

`ifdef PSUM_RELU_EN
  // Clamp every negative two's-complement lane to zero.
  function automatic logic [FIFO_WIDTH-1:0] relu(input logic [FIFO_WIDTH-1:0] w);
    logic [FIFO_WIDTH-1:0] r;
    r = w;
    for (int i = 0; i < int'(LANES); i++) begin
      if (w[i*DATA_WIDTH + DATA_WIDTH - 1]) r[i*DATA_WIDTH +: DATA_WIDTH] = '0;
    end
    return r;
  endfunction
  assign cap_data = relu(bus.rdata_a_psum);
`else
  assign cap_data = bus.rdata_a_psum;
`endif

  // Credit: buffered + in-flight words must stay below 2; a word leaving
  // this cycle frees its slot for the read issued this cycle.
  assign xfer  = bus.out_valid && bus.out_ready;
  assign issue = (state_q == RUN) && (issue_cnt_q != '0) &&
                 ((3'(occ_q) + 3'(inflight_q)) < (3'd2 + 3'(xfer)));

  assign bus.re_a_psum   = issue;
  assign bus.addr_a_psum = ptr_q;
  assign bus.out_valid   = (occ_q != 2'd0);
  assign bus.out_data    = buf_q[rd_ptr_q];

  // State, pointer and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      issue_cnt_q  <= '0;
      accept_cnt_q <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      issue_cnt_q  <= issue_cnt_d;
      accept_cnt_q <= accept_cnt_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

  // Next-state, pointer and counter logic.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    issue_cnt_d  = issue_cnt_q;
    accept_cnt_d = accept_cnt_q;
    if (issue) begin
      ptr_d       = ptr_q + ADDR_STEP;
      issue_cnt_d = issue_cnt_q - CNT_W'(1);
    end
    if (xfer) accept_cnt_d = accept_cnt_q - CNT_W'(1);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (num_words != '0) begin
            state_d      = RUN;
            ptr_d        = base_addr;
            issue_cnt_d  = num_words;
            accept_cnt_d = num_words;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN:   if (issue && issue_cnt_q == CNT_W'(1)) state_d = FLUSH;
      FLUSH: if (xfer && accept_cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // 2-entry output buffer; capture lands one cycle after each read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
    end else begin
      inflight_q <= issue;
      if (inflight_q) begin
        buf_q[wr_ptr_q] <= cap_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (xfer) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + 2'(inflight_q) - 2'(xfer);
    end
  end

endmodule

// File: tb/tb_psum_glb_drain.sv
// Directed bench for psum_glb_drain: GLB model returns word k = {4{16'(k)}}
// for element address 4k; a negedge monitor records reads, transfers,
// stalls and done pulses, and tracks buffer credit independently.
module tb_psum_glb_drain;
  localparam int unsigned FW = 64;
  localparam int unsigned AW = 18;
  localparam int unsigned CW = 16;
  localparam logic [63:0] SPECIAL = 64'h8000_7FFF_FFFF_0001;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] num_words = '0;
  logic          busy, done;

  psum_glb_drain_if #(.FIFO_WIDTH(FW), .ADDR_psum(AW)) bus();

  psum_glb_drain #(.FIFO_WIDTH(FW), .DATA_WIDTH(16), .ADDR_psum(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 0;
  logic special_mode = 1'b0;

  logic [AW-1:0] addr_q[$];
  logic [FW-1:0] data_q[$];
  int xcyc_q[$];
  int valid_cnt = 0, credit_err = 0, hold_err = 0, done_cnt = 0, done_cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] word_of(input int k);
    logic [15:0] kk;
    kk = 16'(k);
    return {kk, kk, kk, kk};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // GLB model: one-cycle read latency.
  initial forever begin
    @(posedge clk);
    if (bus.re_a_psum)
      bus.rdata_a_psum <= special_mode ? SPECIAL : word_of(int'(bus.addr_a_psum >> 2));
  end

  // Downstream ready: always 1, or the repeating 1,0,0,1 pattern.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) bus.out_ready = 1'b1;
      else bus.out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
    end
  end

  // Monitor with independent credit model.
  initial begin
    int m_occ, m_inf, x;
    logic prev_stall;
    logic [FW-1:0] prev_data;
    m_occ = 0; m_inf = 0; prev_stall = 1'b0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_occ = 0; m_inf = 0; prev_stall = 1'b0;
      end else begin
        x = (bus.out_valid && bus.out_ready) ? 1 : 0;
        if (bus.re_a_psum) begin
          addr_q.push_back(bus.addr_a_psum);
          if (m_occ + m_inf - x >= 2) credit_err++;
        end
        if (bus.out_valid) valid_cnt++;
        if (prev_stall && !(bus.out_valid && bus.out_data == prev_data)) hold_err++;
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        if (x == 1) begin
          data_q.push_back(bus.out_data);
          xcyc_q.push_back(cyc);
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        m_occ = m_occ + m_inf - x;
        m_inf = bus.re_a_psum ? 1 : 0;
      end
    end
  end

  task automatic clear_obs();
    addr_q.delete(); data_q.delete(); xcyc_q.delete();
    valid_cnt = 0; credit_err = 0; hold_err = 0;
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input logic [CW-1:0] n, output int sc);
    @(posedge clk); #1;
    base_addr = b; num_words = n; start = 1'b1; sc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_cnt > d0) break;
    end
    check("done_seen", 64'(done_cnt > d0), 64'(1));
  endtask

  task automatic check_stream8(input string tag);
    check({tag, "_nxfer"}, 64'(data_q.size()), 64'(8));
    for (int k = 0; k < 8; k++) check({tag, "_data"}, data_q[k], word_of(k));
    check({tag, "_naddr"}, 64'(addr_q.size()), 64'(8));
    for (int k = 0; k < 8; k++) check({tag, "_addr"}, 64'(addr_q[k]), 64'(4 * k));
  endtask

  initial begin
    int sc, sc2, d0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_re", 64'(bus.re_a_psum), 64'(0));
    check("rst_addr", 64'(bus.addr_a_psum), 64'(0));
    check("rst_valid", 64'(bus.out_valid), 64'(0));
    check("rst_data", bus.out_data, 64'(0));

    // Full-rate drain of 8 words.
    clear_obs(); d0 = done_cnt;
    pulse_start(AW'(0), CW'(8), sc);
    wait_done(d0);
    check("t1_lat", 64'(done_cyc - sc), 64'(11));
    @(negedge clk);
    check("t1_busy_fall", 64'(busy), 64'(0));
    repeat (3) @(negedge clk);
    check("t1_done_once", 64'(done_cnt - d0), 64'(1));
    check_stream8("t1");
    check("t1_b2b", 64'(xcyc_q[7] - xcyc_q[0]), 64'(7));
    check("t1_credit", 64'(credit_err), 64'(0));

    // Backpressured drain.
    clear_obs(); d0 = done_cnt; ready_mode = 1;
    pulse_start(AW'(0), CW'(8), sc);
    wait_done(d0);
    repeat (3) @(negedge clk);
    ready_mode = 0;
    check("t2_done_once", 64'(done_cnt - d0), 64'(1));
    check_stream8("t2");
    check("t2_hold", 64'(hold_err), 64'(0));
    check("t2_credit", 64'(credit_err), 64'(0));

    // Zero-length drain.
    clear_obs(); d0 = done_cnt;
    pulse_start(AW'(0), CW'(0), sc);
    wait_done(d0);
    check("t3_lat", 64'(done_cyc - sc), 64'(1));
    repeat (3) @(negedge clk);
    check("t3_no_re", 64'(addr_q.size()), 64'(0));
    check("t3_no_valid", 64'(valid_cnt), 64'(0));

    // Address wrap.
    clear_obs(); d0 = done_cnt;
    pulse_start(AW'((1 << AW) - 4), CW'(3), sc);
    wait_done(d0);
    check("t4_naddr", 64'(addr_q.size()), 64'(3));
    check("t4_addr0", 64'(addr_q[0]), 64'((1 << AW) - 4));
    check("t4_addr1", 64'(addr_q[1]), 64'(0));
    check("t4_addr2", 64'(addr_q[2]), 64'(4));
    check("t4_nxfer", 64'(data_q.size()), 64'(3));

    // Start while busy is ignored.
    clear_obs(); d0 = done_cnt;
    pulse_start(AW'(0), CW'(8), sc);
    pulse_start(AW'(100), CW'(2), sc2);
    wait_done(d0);
    check("t5_lat", 64'(done_cyc - sc), 64'(11));
    repeat (5) @(negedge clk);
    check("t5_done_once", 64'(done_cnt - d0), 64'(1));
    check_stream8("t5");

    // Reset mid-drain.
    clear_obs(); d0 = done_cnt;
    pulse_start(AW'(0), CW'(8), sc);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t6_busy", 64'(busy), 64'(0));
    check("t6_done", 64'(done), 64'(0));
    check("t6_re", 64'(bus.re_a_psum), 64'(0));
    check("t6_addr", 64'(bus.addr_a_psum), 64'(0));
    check("t6_valid", 64'(bus.out_valid), 64'(0));
    check("t6_data", bus.out_data, 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("t6_no_done", 64'(done_cnt - d0), 64'(0));
    check("t6_idle", 64'(busy), 64'(0));

    // Lane clamp on a mixed-sign word.
    clear_obs(); d0 = done_cnt; special_mode = 1'b1;
    pulse_start(AW'(0), CW'(1), sc);
    wait_done(d0);
    check("t7_nxfer", 64'(data_q.size()), 64'(1));
`ifdef PSUM_RELU_EN
    check("t7_relu", data_q[0], 64'h0000_7FFF_0000_0001);
`else
    check("t7_raw", data_q[0], 64'h8000_7FFF_FFFF_0001);
`endif
    special_mode = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
